// File: rtl/ascon_ctrl_if.sv
// Block and tag handshakes between the pin-level loader and the ASCON control FSM.
// The loader drives the master side; the controller drives the slave side.
interface ascon_ctrl_if;
   logic blk_valid;
   logic blk_last;
   logic blk_ready;
   logic tag_valid;
   logic tag_ready;

   modport master (
      output blk_valid,
      output blk_last,
      output tag_ready,
      input  blk_ready,
      input  tag_valid
   );

   modport slave (
      input  blk_valid,
      input  blk_last,
      input  tag_ready,
      output blk_ready,
      output tag_valid
   );
endinterface

// File: rtl/ascon_ctrl.sv
// ascon_ctrl: ASCON-128 sequencing FSM (init, AD, message, final, tag); one state per cycle, Moore strobes.
// Stalls in the WAIT states until blk_valid and in TAG until tag_ready; ASCON_ABORT_EN adds the abort input.
module ascon_ctrl #(
   parameter int ROUNDS_A = 12,
   parameter int ROUNDS_B = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               decrypt,
   input  logic               no_ad,
`ifdef ASCON_ABORT_EN
   input  logic               abort,
`endif
   ascon_ctrl_if.slave        blk_if,
   output logic               absorb,
   output logic               sel_init,
   output logic               xor_key_lo,
   output logic               xor_dom,
   output logic               xor_key_fin,
   output logic               rnd_en,
   output logic [7:0]         rnd_const,
   output logic               dec_mode,
   output logic               busy,
   output logic [3:0]         phase
);

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_LOAD     = 4'd1,
      S_INIT_P   = 4'd2,
      S_KEY1     = 4'd3,
      S_AD_WAIT  = 4'd4,
      S_AD_P     = 4'd5,
      S_DOM      = 4'd6,
      S_MSG_WAIT = 4'd7,
      S_MSG_P    = 4'd8,
      S_FIN_KEY  = 4'd9,
      S_FIN_P    = 4'd10,
      S_TAG      = 4'd11
   } state_e;

   localparam logic [3:0] LAST_A = 4'(ROUNDS_A - 1);
   localparam logic [3:0] LAST_B = 4'(ROUNDS_B - 1);
   localparam logic [3:0] OFF_A  = 4'(12 - ROUNDS_A);
   localparam logic [3:0] OFF_B  = 4'(12 - ROUNDS_B);

   state_e     state;
   state_e     state_nxt;
   logic [3:0] cnt;
   logic [3:0] cnt_nxt;
   logic       no_ad_q;
   logic       ad_last_q;
   logic       kill;
   logic       wait_st;
   logic       long_perm;
   logic       last_rnd;
   logic [3:0] rc_idx;

`ifdef ASCON_ABORT_EN
   assign kill = abort & (state != S_IDLE);
`else
   assign kill = 1'b0;
`endif

   // Moore strobe decode; only the block handshake looks at inputs.
   assign sel_init         = (state == S_LOAD);
   assign xor_key_lo       = (state == S_KEY1);
   assign xor_dom          = (state == S_DOM);
   assign xor_key_fin      = (state == S_FIN_KEY);
   assign blk_if.tag_valid = (state == S_TAG);
   assign rnd_en           = (state == S_INIT_P) | (state == S_AD_P) |
                             (state == S_MSG_P)  | (state == S_FIN_P);
   assign busy             = (state != S_IDLE);
   assign phase            = state;

   assign wait_st          = (state == S_AD_WAIT) | (state == S_MSG_WAIT);
   assign blk_if.blk_ready = wait_st & ~kill;
   assign absorb           = blk_if.blk_valid & blk_if.blk_ready;

   assign long_perm = (state == S_INIT_P) | (state == S_FIN_P);
   assign last_rnd  = (cnt == (long_perm ? LAST_A : LAST_B));
   // Constant index is offset so shortened permutations use the tail of the 12-round schedule.
   assign rc_idx    = (long_perm ? OFF_A : OFF_B) + cnt;
   assign rnd_const = rnd_en ? {4'hF - rc_idx, rc_idx} : 8'h00;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         cnt       <= 4'd0;
         dec_mode  <= 1'b0;
         no_ad_q   <= 1'b0;
         ad_last_q <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if ((state == S_IDLE) && start) begin
            dec_mode <= decrypt;
            no_ad_q  <= no_ad;
         end
         if ((state == S_AD_WAIT) && absorb)
            ad_last_q <= blk_if.blk_last;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = 4'd0;
      case (state)
         S_IDLE:     if (start) state_nxt = S_LOAD;
         S_LOAD:     state_nxt = S_INIT_P;
         S_INIT_P: begin
            if (last_rnd) state_nxt = S_KEY1;
            else          cnt_nxt   = cnt + 4'd1;
         end
         S_KEY1:     state_nxt = no_ad_q ? S_DOM : S_AD_WAIT;
         S_AD_WAIT:  if (absorb) state_nxt = S_AD_P;
         S_AD_P: begin
            if (last_rnd) state_nxt = ad_last_q ? S_DOM : S_AD_WAIT;
            else          cnt_nxt   = cnt + 4'd1;
         end
         S_DOM:      state_nxt = S_MSG_WAIT;
         S_MSG_WAIT: if (absorb) state_nxt = blk_if.blk_last ? S_FIN_KEY : S_MSG_P;
         S_MSG_P: begin
            if (last_rnd) state_nxt = S_MSG_WAIT;
            else          cnt_nxt   = cnt + 4'd1;
         end
         S_FIN_KEY:  state_nxt = S_FIN_P;
         S_FIN_P: begin
            if (last_rnd) state_nxt = S_TAG;
            else          cnt_nxt   = cnt + 4'd1;
         end
         S_TAG:      if (blk_if.tag_ready) state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
      if (kill) begin
         state_nxt = S_IDLE;
         cnt_nxt   = 4'd0;
      end
   end

endmodule

// File: tb/tb_ascon_ctrl.sv
// Directed bench for ascon_ctrl: per-cycle expected output vectors queued from the
// documented timelines and compared against the DUT half a cycle after each edge.
module tb_ascon_ctrl;

   typedef struct packed {
      logic       busy;
      logic       dec;
      logic       sel_init;
      logic       rnd_en;
      logic       key_lo;
      logic       dom;
      logic       blk_ready;
      logic       absorb;
      logic       key_fin;
      logic       tag_valid;
      logic [7:0] rc;
   } obs_t;

   typedef enum int {K_IDLE, K_LOAD, K_RND, K_KEY1, K_DOM, K_WAIT, K_ABS, K_FINKEY, K_TAG} kind_e;

   logic       clk;
   logic       rst;
   logic       start;
   logic       decrypt;
   logic       no_ad;
   logic       abort;
   logic       absorb;
   logic       sel_init;
   logic       xor_key_lo;
   logic       xor_dom;
   logic       xor_key_fin;
   logic       rnd_en;
   logic [7:0] rnd_const;
   logic       dec_mode;
   logic       busy;
   logic [3:0] phase;

   ascon_ctrl_if bi ();

   ascon_ctrl #(.ROUNDS_A(12), .ROUNDS_B(6)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .decrypt     (decrypt),
      .no_ad       (no_ad),
`ifdef ASCON_ABORT_EN
      .abort       (abort),
`endif
      .blk_if      (bi),
      .absorb      (absorb),
      .sel_init    (sel_init),
      .xor_key_lo  (xor_key_lo),
      .xor_dom     (xor_dom),
      .xor_key_fin (xor_key_fin),
      .rnd_en      (rnd_en),
      .rnd_const   (rnd_const),
      .dec_mode    (dec_mode),
      .busy        (busy),
      .phase       (phase)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] rc_tab [12] = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
                               8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};

   obs_t  exp_q[$];
   logic  exp_dec;
   string tag;
   int    cyc_n;
   int    n_chk;
   int    n_fail;

   task automatic push_seg(input kind_e k, input int n);
      obs_t e;
      for (int i = 0; i < n; i++) begin
         e      = '0;
         e.dec  = exp_dec;
         e.busy = (k != K_IDLE);
         case (k)
            K_LOAD:   e.sel_init = 1'b1;
            K_RND:    begin e.rnd_en = 1'b1; e.rc = rc_tab[12 - n + i]; end
            K_KEY1:   e.key_lo = 1'b1;
            K_DOM:    e.dom = 1'b1;
            K_WAIT:   e.blk_ready = 1'b1;
            K_ABS:    begin e.blk_ready = 1'b1; e.absorb = 1'b1; end
            K_FINKEY: e.key_fin = 1'b1;
            K_TAG:    e.tag_valid = 1'b1;
            default:  ;
         endcase
         exp_q.push_back(e);
      end
   endtask

   task automatic chk_now();
      obs_t o;
      obs_t e;
      o = {busy, dec_mode, sel_init, rnd_en, xor_key_lo, xor_dom, bi.blk_ready,
           absorb, xor_key_fin, bi.tag_valid, rnd_const};
      n_chk++;
      assert (exp_q.size() != 0) else begin
         n_fail++;
         $error("FAIL %s cycle %0d: observed %h with no expected entry queued", tag, cyc_n, o);
      end
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         n_chk++;
         assert (o === e) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc_n, o, e);
         end
      end
   endtask

   task automatic cyc(input int c, input logic st, input logic bv, input logic bl,
                      input logic tr, input logic dcr, input logic nad, input logic ab);
      @(negedge clk);
      cyc_n        = c;
      start        = st;
      bi.blk_valid = bv;
      bi.blk_last  = bl;
      bi.tag_ready = tr;
      decrypt      = dcr;
      no_ad        = nad;
      abort        = ab;
      #1;
      chk_now();
   endtask

   task automatic start_op(input logic dcr, input logic nad);
      @(negedge clk);
      start   = 1'b1;
      decrypt = dcr;
      no_ad   = nad;
   endtask

   task automatic push_s1();
      push_seg(K_LOAD, 1);
      push_seg(K_RND, 12);
      push_seg(K_KEY1, 1);
      push_seg(K_DOM, 1);
      push_seg(K_ABS, 1);
      push_seg(K_FINKEY, 1);
      push_seg(K_RND, 12);
      push_seg(K_TAG, 1);
      push_seg(K_IDLE, 1);
   endtask

   initial begin
      n_chk = 0; n_fail = 0; cyc_n = 0;
      rst = 1'b0; start = 1'b0; decrypt = 1'b0; no_ad = 1'b0; abort = 1'b0;
      bi.blk_valid = 1'b0; bi.blk_last = 1'b0; bi.tag_ready = 1'b0;
      exp_dec = 1'b0;

      tag = "reset";
      #12;
      push_seg(K_IDLE, 1);
      chk_now();
      @(negedge clk);
      rst = 1'b1;

      // no_ad, single message block; no_ad driven low after start must not matter
      tag = "s1_no_ad";
      exp_dec = 1'b0;
      push_s1();
      start_op(1'b0, 1'b1);
      for (int c = 1; c <= 31; c++) cyc(c, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

      // one AD block + one message block, decrypt latched then dropped
      tag = "s2_ad_msg";
      exp_dec = 1'b1;
      push_seg(K_LOAD, 1);
      push_seg(K_RND, 12);
      push_seg(K_KEY1, 1);
      push_seg(K_ABS, 1);
      push_seg(K_RND, 6);
      push_seg(K_DOM, 1);
      push_seg(K_ABS, 1);
      push_seg(K_FINKEY, 1);
      push_seg(K_RND, 12);
      push_seg(K_TAG, 1);
      push_seg(K_IDLE, 1);
      start_op(1'b1, 1'b0);
      for (int c = 1; c <= 38; c++) cyc(c, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

      // toggling blk_valid, stray start/tag_ready pulses, tag held one extra cycle
      tag = "s4_stall";
      exp_dec = 1'b0;
      push_seg(K_LOAD, 1);
      push_seg(K_RND, 12);
      push_seg(K_KEY1, 1);
      push_seg(K_WAIT, 1);
      push_seg(K_ABS, 1);
      push_seg(K_RND, 6);
      push_seg(K_DOM, 1);
      push_seg(K_ABS, 1);
      push_seg(K_FINKEY, 1);
      push_seg(K_RND, 12);
      push_seg(K_TAG, 2);
      push_seg(K_IDLE, 2);
      start_op(1'b0, 1'b0);
      for (int c = 1; c <= 41; c++)
         cyc(c, (c == 5) || (c == 20) || (c == 38), (c % 2) == 0, 1'b1,
             (c == 10) || (c == 39), 1'b1, 1'b1, 1'b0);

      // reset pulled during FIN_P round 5, then a clean rerun of scenario 1
      tag = "s5_reset";
      exp_dec = 1'b0;
      push_s1();
      start_op(1'b0, 1'b1);
      for (int c = 1; c <= 22; c++) cyc(c, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      exp_q.delete();
      #1;
      rst = 1'b0;
      #1;
      push_seg(K_IDLE, 1);
      chk_now();
      @(negedge clk);
      rst = 1'b1;
      tag = "s5_rerun";
      push_s1();
      start_op(1'b0, 1'b1);
      for (int c = 1; c <= 31; c++) cyc(c, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef ASCON_ABORT_EN
      // abort in the second AD_P round while a block is offered
      tag = "s6_abort";
      exp_dec = 1'b0;
      push_seg(K_LOAD, 1);
      push_seg(K_RND, 12);
      push_seg(K_KEY1, 1);
      push_seg(K_ABS, 1);
      push_seg(K_RND, 6);
      start_op(1'b0, 1'b0);
      for (int c = 1; c <= 16; c++) cyc(c, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(17, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      exp_q.delete();
      push_seg(K_IDLE, 2);
      for (int c = 18; c <= 19; c++) cyc(c, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

      tag = "drain";
      n_chk++;
      assert (exp_q.size() == 0) else begin
         n_fail++;
         $error("FAIL %s: observed %0d leftover entries expected 0", tag, exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ascon_ctrl.md
Name: ascon_ctrl

Overview:
- Control FSM that sequences the ASCON-128 datapath: initialization, associated-data absorption, message processing, finalization and tag release.
- Drives the permutation core per cycle with round-enable, round constant and one-cycle state-update strobes.
- Sits between the pin-level loader, which supplies 64-bit blocks via a valid/ready handshake, and the ascon_wrapper datapath.

Parameters:
ROUNDS_A, 12, rounds of p^a (init/final); legal 1..12
ROUNDS_B, 6, rounds of p^b (AD/message); legal 1..12

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
start  in  1  begin operation; honoured only in IDLE
decrypt  in  1  sampled on accepted start; drives dec_mode
no_ad  in  1  sampled on accepted start; skip AD phase
blk_valid  in  1  loader has a block
blk_last  in  1  qualifies blk_valid: final block of current phase
blk_ready  out  1  controller accepts a block this cycle
absorb  out  1  XOR/replace block into rate; equals blk_valid & blk_ready
sel_init  out  1  load IV||K||N into state
xor_key_lo  out  1  XOR 0||K after init permutation
xor_dom  out  1  XOR domain-separation bit
xor_key_fin  out  1  XOR K into capacity before final permutation
rnd_en  out  1  perform one permutation round this cycle
rnd_const  out  8  round constant for the current round
dec_mode  out  1  registered decrypt flag
tag_valid  out  1  tag available on datapath
tag_ready  in  1  tag consumed
busy  out  1  high whenever state != IDLE
phase  out  4  state encoding, debug

Behaviour:
- Reset (rst=0, async): state=IDLE, round counter=0. All outputs 0; rnd_const=0.
- Every strobe output is a Moore decode of state, except absorb and blk_ready.
- States and transitions:
  - IDLE -> LOAD on start.
  - LOAD: sel_init=1 for one cycle -> INIT_P.
  - INIT_P: rnd_en=1 for ROUNDS_A cycles -> KEY1.
  - KEY1: xor_key_lo=1 for one cycle -> DOM if no_ad, else AD_WAIT.
  - AD_WAIT: blk_ready=1. On accept -> AD_P; the last flag is registered.
  - AD_P: ROUNDS_B rounds -> DOM if the registered last flag is set, else AD_WAIT.
  - DOM: xor_dom=1 for one cycle -> MSG_WAIT.
  - MSG_WAIT: blk_ready=1. On accept with blk_last=0 -> MSG_P; with blk_last=1 -> FIN_KEY.
  - MSG_P: ROUNDS_B rounds -> MSG_WAIT.
  - FIN_KEY: xor_key_fin=1 for one cycle -> FIN_P.
  - FIN_P: ROUNDS_A rounds -> TAG.
  - TAG: tag_valid=1 until tag_ready=1 is sampled -> IDLE.
- Round counter: 4-bit, cleared on entry to any *_P state, increments each rnd_en cycle. The state exits when counter == R-1.
- rnd_const: i = (12-R) + counter; value = {4'hF - i, i[3:0]}. For R=12 the sequence is 0xF0,0xE1,...,0x4B. For R=6 it starts 0x96 and ends 0x4B. rnd_const is 0 when rnd_en=0.
- Timing with start accepted at edge 0:
  - LOAD occupies cycle 1.
  - INIT_P occupies cycles 2..13.
  - KEY1 occupies cycle 14.
  - blk_ready first rises in cycle 15 with AD, or cycle 16 with no_ad.
- Boundary conditions:
  - A message phase always contains at least one block; the loader pads.
  - blk_valid outside AD_WAIT/MSG_WAIT is ignored and is not a protocol error.
  - start while busy is ignored, including in TAG.
  - decrypt and no_ad are latched only on an accepted start.
  - blk_last without blk_valid has no effect.
  - tag_ready outside TAG is ignored.
  - rst asserted mid-operation returns to IDLE immediately; no outputs glitch high.

Optional Feature:
- Macro ASCON_ABORT_EN adds input port abort (1 bit).
  - With the macro defined: abort=1 in any non-IDLE state forces IDLE on the next edge, clears the counter and deasserts all strobes. abort has priority over every transition, including a simultaneous block accept or tag_ready.
  - Without the macro: the port does not exist and operations always run to TAG.

Test Plan:
1. no_ad=1, one message block held valid with blk_last=1, tag_ready=1 -> sel_init at cycle 1; rnd_en cycles 2..13; xor_key_lo at 14; xor_dom at 15; absorb at 16; xor_key_fin at 17; rnd_en 18..29; tag_valid at cycle 30; busy=0 at cycle 31.
2. One AD block plus one message block, both always valid -> absorb at cycles 15 and 23; xor_dom at 22; tag_valid at cycle 37.
3. rnd_const check -> INIT_P emits 0xF0,0xE1,0xD2,0xC3,0xB4,0xA5,0x96,0x87,0x78,0x69,0x5A,0x4B; AD_P emits 0x96..0x4B.
4. blk_valid toggled 0/1 and start pulsed during permutations -> no absorb outside WAIT states; start ignored; final tag timing shifts by exactly the stall cycles.
5. rst pulled low during FIN_P round 5 -> all outputs 0 asynchronously; a fresh start after release reproduces scenario 1 timing.
6. (ASCON_ABORT_EN) abort in AD_P coinciding with blk_valid -> IDLE next cycle, no absorb, busy=0.
